// File: rtl/fa_bist_pkg.sv
// Shared types and widths for the full-adder BIST controller.
// The expected-response helper gives the 2-bit arithmetic sum of a vector.
package fa_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VEC  = 8;
  localparam int VEC_W    = 3;
  localparam int SETTLE_W = 4;
  localparam int COUNT_W  = 4;

  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(NUM_VEC);
  localparam logic [VEC_W-1:0]   VEC_LAST  = VEC_W'(NUM_VEC - 1);

  function automatic logic [1:0] fa_sum(input logic [VEC_W-1:0] v);
    return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/fa_bist.sv
// Exhaustive BIST for an external full adder: applies vectors 0..7, holds each
// SETTLE cycles, compares {co,s} against a+b+ci and records per-vector failures.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic         a,
  output logic         b,
  output logic         ci,
  input  logic         s,
  input  logic         co,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   fail_mask,
  output logic [3:0]   fail_count
);

  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE - 1);

  state_t               state, state_nxt;
  logic [VEC_W-1:0]     vec, vec_nxt;
  logic [SETTLE_W-1:0]  cnt, cnt_nxt;
  logic [7:0]           mask, mask_nxt;
  logic [COUNT_W-1:0]   count, count_nxt;
  logic                 miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec   <= '0;
      cnt   <= '0;
      mask  <= '0;
      count <= '0;
    end else begin
      vec   <= vec_nxt;
      cnt   <= cnt_nxt;
      mask  <= mask_nxt;
      count <= count_nxt;
    end
  end

  assign miss = ({co, s} != fa_sum(vec));

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    mask_nxt  = mask;
    count_nxt = count;
    case (state)
      IDLE, DONE: begin
        // abort outranks start even where abort itself has nothing to stop
        if (start && !abort) begin
          state_nxt = RUN;
          vec_nxt   = '0;
          cnt_nxt   = SETTLE_INIT;
          mask_nxt  = '0;
          count_nxt = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          vec_nxt   = '0;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          if (miss) begin
            mask_nxt[vec] = 1'b1;
            count_nxt     = (count >= COUNT_MAX) ? count : count + 1'b1;
          end
          if (vec == VEC_LAST) begin
            state_nxt = DONE;
          end else begin
            vec_nxt = vec + 1'b1;
            cnt_nxt = SETTLE_INIT;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign {a, b, ci}  = vec;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign pass        = done && (count == '0);
  assign fail_mask   = mask;
  assign fail_count  = count;

endmodule

// File: tb/tb_fa_bist.sv
// Randomized bench for fa_bist: two instances (SETTLE=2 and SETTLE=1) driving
// table-based adder models; results are predicted from the response tables.
module tb_fa_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start, abort, a, b, ci, s, co, busy, done, pass;
  logic [7:0]  fail_mask [2];
  logic [3:0]  fail_count [2];
  logic [1:0]  resp [2][8];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fa_bist #(.SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .a(a[0]), .b(b[0]), .ci(ci[0]), .s(s[0]), .co(co[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_mask(fail_mask[0]), .fail_count(fail_count[0])
  );

  fa_bist #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .a(a[1]), .b(b[1]), .ci(ci[1]), .s(s[1]), .co(co[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_mask(fail_mask[1]), .fail_count(fail_count[1])
  );

  // Adder under test: response looked up per applied vector.
  assign {co[0], s[0]} = resp[0][{a[0], b[0], ci[0]}];
  assign {co[1], s[1]} = resp[1][{a[1], b[1], ci[1]}];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int ref_sum(input int k);
    return (k / 4) + ((k / 2) % 2) + (k % 2);
  endfunction

  function automatic logic [7:0] ref_mask(input int i);
    logic [7:0] m = '0;
    for (int k = 0; k < 8; k++)
      if (int'(resp[i][k]) != ref_sum(k)) m[k] = 1'b1;
    return m;
  endfunction

  function automatic int popcount8(input logic [7:0] m);
    int c = 0;
    for (int k = 0; k < 8; k++) c += int'(m[k]);
    return c;
  endfunction

  // mode 0 good, 1 s stuck-at-0, 2 co inverted, 3 random responses
  task automatic set_resp(input int i, input int mode);
    for (int k = 0; k < 8; k++) begin
      int g = ref_sum(k);
      case (mode)
        0:       resp[i][k] = 2'(g);
        1:       resp[i][k] = 2'(g & 2);
        2:       resp[i][k] = 2'(g ^ 2);
        default: resp[i][k] = 2'($urandom_range(0, 3));
      endcase
    end
  endtask

  function automatic logic [17:0] outs(input int i);
    return {a[i], b[i], ci[i], busy[i], done[i], pass[i], fail_mask[i], fail_count[i]};
  endfunction

  task automatic start_run(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[i] = 1'b0;
    check("busy_after_start", 32'(busy[i]), 32'd1);
    check("done_after_start", 32'(done[i]), 32'd0);
    check("mask_cleared", 32'(fail_mask[i]), 32'd0);
    check("count_cleared", 32'(fail_count[i]), 32'd0);
  endtask

  // Called at the negedge after the start edge; counts edges until done.
  task automatic wait_done(input int i);
    int cyc = 0;
    while (!done[i] && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("latency", 32'(cyc), 32'(8 * settle_of(i)));
  endtask

  task automatic check_result(input int i);
    logic [7:0] m = ref_mask(i);
    check("fail_mask", 32'(fail_mask[i]), 32'(m));
    check("fail_count", 32'(fail_count[i]), 32'(popcount8(m)));
    check("pass", 32'(pass[i]), 32'(m == 8'h00));
    check("busy_in_done", 32'(busy[i]), 32'd0);
  endtask

  task automatic run_full(input int i);
    start_run(i);
    wait_done(i);
    check_result(i);
  endtask

  task automatic wait_vec(input int i, input int v);
    int n = 0;
    while (int'({a[i], b[i], ci[i]}) != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec", 32'({a[i], b[i], ci[i]}), 32'(v));
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    abort = '0;
    set_resp(0, 0);
    set_resp(1, 0);
    #1;
    check("reset_outs0", 32'(outs(0)), 32'd0);
    check("reset_outs1", 32'(outs(1)), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // good adder, SETTLE=2: 16-cycle run, pass
    run_full(0);
    check("good_pass", 32'(pass[0]), 32'd1);
    repeat (3) @(negedge clk);
    check("done_hold", 32'(done[0]), 32'd1);
    check("mask_hold", 32'(fail_mask[0]), 32'd0);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_in_done", 32'(done[0]), 32'd1);

    // s stuck-at-0
    set_resp(0, 1);
    run_full(0);
    check("sa0_mask", 32'(fail_mask[0]), 32'h96);
    check("sa0_count", 32'(fail_count[0]), 32'd4);

    // co inverted, started straight from a failing DONE
    set_resp(0, 2);
    run_full(0);
    check("coinv_count", 32'(fail_count[0]), 32'd8);

    // SETTLE=1, start held high: ignored in RUN, restarts from DONE
    set_resp(1, 0);
    @(negedge clk);
    start[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(1);
    check_result(1);
    @(posedge clk);
    @(negedge clk);
    check("restart_done", 32'(done[1]), 32'd0);
    check("restart_busy", 32'(busy[1]), 32'd1);
    start[1] = 1'b0;
    wait_done(1);
    check_result(1);

    // abort during vector 3, together with start
    start_run(1);
    wait_vec(1, 3);
    abort[1] = 1'b1;
    start[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outs", 32'(outs(1)), 32'd0);
    abort[1] = 1'b0;
    start[1] = 1'b0;
    @(negedge clk);
    check("abort_stays_idle", 32'(outs(1)), 32'd0);

    // async reset mid-run during vector 5 of a failing run
    set_resp(0, 2);
    start_run(0);
    wait_vec(0, 5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_outs0", 32'(outs(0)), 32'd0);
    check("rst_outs1", 32'(outs(1)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(outs(0)), 32'd0);
    set_resp(0, 0);
    run_full(0);
    check("post_rst_pass", 32'(pass[0]), 32'd1);

    // randomized response tables on either instance
    for (int it = 0; it < 12; it++) begin
      int i = int'($urandom_range(0, 1));
      set_resp(i, ($urandom_range(0, 3) == 0) ? 0 : 3);
      run_full(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fa_bist.md
FA_BIST -- requirements
Module: fa_bist

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning clock cycles each vector is held before its response is sampled; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a pulse or level that begins a test run from IDLE or DONE.
REQ-005 The block SHALL have port abort, input, 1, which terminates a run in progress.
REQ-006 The block SHALL have ports a, b, ci, output, 1 each, registered stimulus to the full adder under test.
REQ-007 The block SHALL have ports s, co, input, 1 each, sum and carry returned by the full adder under test.
REQ-008 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-009 The block SHALL have port done, output, 1, high while the block is in DONE.
REQ-010 The block SHALL have port pass, output, 1, which is valid only while done is high.
REQ-011 The block SHALL have port fail_mask, output, 8, where bit k is set if vector k ({a,b,ci}=k) miscompared.
REQ-012 The block SHALL have port fail_count, output, 4, giving the number of miscompared vectors (0..8).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE or DONE with start=1, the block SHALL on that edge enter RUN, drive {a,b,ci}=3'd0, load the settle counter with SETTLE-1, and clear fail_mask and fail_count.
REQ-015 In RUN, the settle counter SHALL decrement each cycle; on the edge where it equals 0, the block SHALL compare {co,s} against the 2-bit sum a+b+ci of the currently driven vector.
REQ-016 On a miscompare, the block SHALL set fail_mask[vec] and increment fail_count on that same edge.
REQ-017 On a compare edge with vec<7, the block SHALL drive vec+1 and reload the counter on the same edge; vectors SHALL be applied in ascending order 0..7.
REQ-018 On the compare edge for vec=7, the block SHALL enter DONE; done=1, busy=0, pass=(final fail_count==0).
REQ-019 The start edge to the done edge SHALL be exactly 8*SETTLE cycles.
REQ-020 start while in RUN SHALL be ignored.
REQ-021 abort in RUN SHALL enter IDLE on the next edge, drive a=b=ci=0, and retain the partial fail_mask and fail_count; pass SHALL be 0.
REQ-022 abort and start asserted together SHALL give abort priority; abort in IDLE or DONE SHALL have no effect.
REQ-023 In DONE, the block SHALL hold all outputs stable until start (restart) or rst.
REQ-024 fail_count SHALL never wrap; its maximum value is 8.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force state IDLE and a=b=ci=0, busy=0, done=0, pass=0, fail_mask=0, fail_count=0, and settle counter=0.
REQ-026 rst asserted mid-run SHALL discard all results; after rst deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-027 The shared package fa_bist_pkg SHALL hold the state enum (IDLE, RUN, DONE), NUM_VEC=8, and the counter widths (vector 3 bits, settle 4 bits, count 4 bits).
REQ-028 Expected-value generation SHALL be inline (a+b+ci); no sub-module is required, and the full adder under test SHALL be external to fa_bist.

Verification
REQ-029 Good full adder, SETTLE=2, 1-cycle start pulse -> done rises 16 cycles later; pass=1, fail_mask=8'h00, fail_count=0.
REQ-030 Model with s stuck-at-0 -> fail_mask=8'h96 (vectors 1,2,4,7), fail_count=4, pass=0.
REQ-031 Model with co inverted -> fail_mask=8'hFF, fail_count=8, pass=0; fail_count does not wrap.
REQ-032 Good full adder, SETTLE=1, abort asserted during vector 3 -> IDLE next edge, busy=0, done=0, fail_mask=0; start held high throughout the run -> no restart until DONE.
REQ-033 rst pulsed asynchronously (between edges) during vector 5 of a failing run -> all outputs 0 immediately; a subsequent start with a good full adder -> pass=1.
REQ-034 Back-to-back: start asserted in DONE -> new run begins on that edge, fail_mask cleared, done drops.
